// File: rtl/sel_pkg.sv
// Shared constants for the N-to-1 selector: mode encodings, default sizes
// and the modulo-N increment used for the round-robin pointer.
package sel_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int DEF_N = 4;
  localparam int DEF_W = 2;

  // Wraps N-1 straight to 0 so a non-power-of-two N never reaches an unused index.
  function automatic int wrap_inc(input int v, input int n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first valid channel at or after ptr,
// scanning ptr, ptr+1, ... modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [SW-1:0] i_ptr,
  output logic [SW-1:0] o_grant,
  output logic          o_grant_valid
);

  logic [SW-1:0] w_idx;

  // Scan from the far end back toward ptr so the nearest hit is assigned last.
  always_comb begin
    o_grant       = '0;
    o_grant_valid = 1'b0;
    w_idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = SW'((int'(i_ptr) + k) % N);
      if (i_valid[w_idx]) begin
        o_grant       = w_idx;
        o_grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sel_n_1_rr.sv
// N-to-1 channel selector with a registered, back-pressurable output;
// picks a channel either by SEL_IN or by round-robin over valid inputs.
module sel_n_1_rr
  import sel_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int W  = DEF_W,
  localparam int SW = $clog2(N)
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           MODE,
  input  logic [SW-1:0]  SEL_IN,
  input  logic [N*W-1:0] IN_DATA,
  input  logic [N-1:0]   IN_VALID,
  output logic [N-1:0]   IN_READY,
  output logic [W-1:0]   OUT,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic [SW-1:0]  OUT_CH
);

  logic [W-1:0]  r_out;
  logic [SW-1:0] r_out_ch;
  logic          r_out_valid;
  logic [SW-1:0] r_ptr;

  logic          w_load;
  logic          w_man_valid;
  logic [SW-1:0] w_rr_grant;
  logic          w_rr_valid;
  logic [SW-1:0] w_grant;
  logic          w_grant_valid;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .i_valid       (IN_VALID),
    .i_ptr         (r_ptr),
    .o_grant       (w_rr_grant),
    .o_grant_valid (w_rr_valid)
  );

  assign w_load = !r_out_valid || OUT_READY;

  // Out-of-range SEL_IN (possible only for non-power-of-two N) never grants.
  always_comb begin
    w_man_valid = 1'b0;
    if (int'(SEL_IN) < N)
      w_man_valid = IN_VALID[SEL_IN];
  end

  always_comb begin
    w_grant       = SEL_IN;
    w_grant_valid = w_man_valid;
    if (MODE == MODE_RR) begin
      w_grant       = w_rr_grant;
      w_grant_valid = w_rr_valid;
    end
  end

  always_comb begin
    IN_READY = '0;
    if (RST_N && w_load && w_grant_valid)
      IN_READY[w_grant] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_out       <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else if (w_load) begin
      if (w_grant_valid) begin
        r_out       <= IN_DATA[int'(w_grant) * W +: W];
        r_out_ch    <= w_grant;
        r_out_valid <= 1'b1;
        if (MODE == MODE_RR)
          r_ptr <= SW'(wrap_inc(int'(w_grant), N));
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign OUT       = r_out;
  assign OUT_CH    = r_out_ch;
  assign OUT_VALID = r_out_valid;

endmodule

// File: tb/tb_sel_n_1_rr.sv
// Directed bench for sel_n_1_rr (N=4, W=2): reset, manual select,
// round-robin dense/sparse, backpressure and reset in mid-stream.
module tb_sel_n_1_rr;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int SW = 2;

  logic           CLK;
  logic           RST_N;
  logic           MODE;
  logic [SW-1:0]  SEL_IN;
  logic [N*W-1:0] IN_DATA;
  logic [N-1:0]   IN_VALID;
  logic [N-1:0]   IN_READY;
  logic [W-1:0]   OUT;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic [SW-1:0]  OUT_CH;

  int n_checks;
  int n_fail;

  sel_n_1_rr #(.N(N), .W(W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .MODE      (MODE),
    .SEL_IN    (SEL_IN),
    .IN_DATA   (IN_DATA),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_CH    (OUT_CH)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N     = 1'b0;
    MODE      = 1'b1;
    SEL_IN    = '0;
    IN_DATA   = 8'b11_10_01_00;
    IN_VALID  = 4'b1111;
    OUT_READY = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (OUT !== 2'd0) begin
        n_fail++; $display("FAIL reset_out cyc=%0d got=%0d exp=0", c, OUT);
      end
      n_checks++;
      if (OUT_VALID !== 1'b0) begin
        n_fail++; $display("FAIL reset_out_valid cyc=%0d got=%0b exp=0", c, OUT_VALID);
      end
      n_checks++;
      if (IN_READY !== 4'b0000) begin
        n_fail++; $display("FAIL reset_in_ready cyc=%0d got=%b exp=0000", c, IN_READY);
      end
      $display("reset cyc=%0d out=%0d out_valid=%0b in_ready=%b", c, OUT, OUT_VALID, IN_READY);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_manual();
    MODE      = 1'b0;
    IN_DATA   = 8'b11_10_01_00;
    IN_VALID  = 4'b1111;
    OUT_READY = 1'b1;
    for (int s = 0; s < 4; s++) begin
      SEL_IN = SW'(s);
      #1;
      n_checks++;
      if (IN_READY !== 4'(1 << s)) begin
        n_fail++; $display("FAIL manual_in_ready sel=%0d got=%b exp=%b", s, IN_READY, 4'(1 << s));
      end
      tick();
      n_checks++;
      if (OUT !== W'(s) || OUT_CH !== SW'(s) || OUT_VALID !== 1'b1) begin
        n_fail++;
        $display("FAIL manual_out sel=%0d got out=%0d ch=%0d v=%0b exp out=%0d ch=%0d v=1",
                 s, OUT, OUT_CH, OUT_VALID, s, s);
      end
      $display("manual sel=%0d out=%0d ch=%0d v=%0b", s, OUT, OUT_CH, OUT_VALID);
    end
    // Selected channel not valid: no grant, output drains but keeps data.
    SEL_IN   = 2'd2;
    IN_VALID = 4'b1011;
    #1;
    n_checks++;
    if (IN_READY !== 4'b0000) begin
      n_fail++; $display("FAIL manual_nogrant_ready got=%b exp=0000", IN_READY);
    end
    tick();
    n_checks++;
    if (OUT_VALID !== 1'b0 || OUT !== 2'd3 || OUT_CH !== 2'd3) begin
      n_fail++;
      $display("FAIL manual_nogrant_out got out=%0d ch=%0d v=%0b exp out=3 ch=3 v=0",
               OUT, OUT_CH, OUT_VALID);
    end
    $display("manual nogrant out=%0d ch=%0d v=%0b", OUT, OUT_CH, OUT_VALID);
  endtask

  task automatic test_rr_all();
    logic [SW-1:0] exp_ch [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    MODE      = 1'b1;
    IN_DATA   = 8'b11_10_01_00;
    IN_VALID  = 4'b1111;
    OUT_READY = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (IN_READY !== 4'(1 << exp_ch[c])) begin
        n_fail++; $display("FAIL rr_all_ready cyc=%0d got=%b exp=%b", c, IN_READY, 4'(1 << exp_ch[c]));
      end
      tick();
      n_checks++;
      if (OUT_CH !== exp_ch[c] || OUT !== W'(exp_ch[c]) || OUT_VALID !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_all_out cyc=%0d got ch=%0d out=%0d v=%0b exp ch=%0d out=%0d v=1",
                 c, OUT_CH, OUT, OUT_VALID, exp_ch[c], exp_ch[c]);
      end
      $display("rr_all cyc=%0d ch=%0d out=%0d v=%0b", c, OUT_CH, OUT, OUT_VALID);
    end
  endtask

  task automatic test_rr_sparse();
    logic [SW-1:0] exp_ch [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    pulse_reset();
    MODE      = 1'b1;
    IN_DATA   = 8'b00_01_10_11;
    IN_VALID  = 4'b1010;
    OUT_READY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (IN_READY !== 4'(1 << exp_ch[c])) begin
        n_fail++; $display("FAIL rr_sparse_ready cyc=%0d got=%b exp=%b", c, IN_READY, 4'(1 << exp_ch[c]));
      end
      tick();
      n_checks++;
      if (OUT_CH !== exp_ch[c] || OUT !== W'(3 - exp_ch[c]) || OUT_VALID !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_sparse_out cyc=%0d got ch=%0d out=%0d v=%0b exp ch=%0d out=%0d v=1",
                 c, OUT_CH, OUT, OUT_VALID, exp_ch[c], 3 - exp_ch[c]);
      end
      $display("rr_sparse cyc=%0d ch=%0d out=%0d v=%0b", c, OUT_CH, OUT, OUT_VALID);
    end
  endtask

  task automatic test_backpressure();
    pulse_reset();
    MODE      = 1'b1;
    IN_DATA   = 8'b11_10_01_00;
    IN_VALID  = 4'b1111;
    OUT_READY = 1'b1;
    tick();
    tick();
    n_checks++;
    if (OUT_CH !== 2'd1 || OUT_VALID !== 1'b1) begin
      n_fail++; $display("FAIL bp_setup got ch=%0d v=%0b exp ch=1 v=1", OUT_CH, OUT_VALID);
    end
    OUT_READY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      // Inputs churn during the stall; the held output must not follow.
      IN_DATA = (c == 1) ? 8'b00_01_10_11 : 8'b11_10_01_00;
      MODE    = (c == 2) ? 1'b0 : 1'b1;
      SEL_IN  = 2'd0;
      #1;
      n_checks++;
      if (IN_READY !== 4'b0000) begin
        n_fail++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", c, IN_READY);
      end
      tick();
      n_checks++;
      if (OUT !== 2'd1 || OUT_CH !== 2'd1 || OUT_VALID !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got out=%0d ch=%0d v=%0b exp out=1 ch=1 v=1",
                 c, OUT, OUT_CH, OUT_VALID);
      end
      $display("bp stall cyc=%0d out=%0d ch=%0d v=%0b", c, OUT, OUT_CH, OUT_VALID);
    end
    MODE      = 1'b1;
    IN_DATA   = 8'b11_10_01_00;
    OUT_READY = 1'b1;
    #1;
    n_checks++;
    if (IN_READY !== 4'b0100) begin
      n_fail++; $display("FAIL bp_release_ready got=%b exp=0100", IN_READY);
    end
    tick();
    n_checks++;
    if (OUT_CH !== 2'd2 || OUT !== 2'd2 || OUT_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_out got ch=%0d out=%0d v=%0b exp ch=2 out=2 v=1", OUT_CH, OUT, OUT_VALID);
    end
    $display("bp release ch=%0d out=%0d v=%0b", OUT_CH, OUT, OUT_VALID);
  endtask

  task automatic test_reset_midstream();
    pulse_reset();
    MODE      = 1'b1;
    IN_DATA   = 8'b11_10_01_00;
    IN_VALID  = 4'b1111;
    OUT_READY = 1'b1;
    tick();
    tick();
    n_checks++;
    if (OUT_CH !== 2'd1 || OUT_VALID !== 1'b1) begin
      n_fail++; $display("FAIL midrst_setup got ch=%0d v=%0b exp ch=1 v=1", OUT_CH, OUT_VALID);
    end
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (IN_READY !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_ready got=%b exp=0000", IN_READY);
    end
    tick();
    n_checks++;
    if (OUT_VALID !== 1'b0 || OUT !== 2'd0 || OUT_CH !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_clear got out=%0d ch=%0d v=%0b exp out=0 ch=0 v=0", OUT, OUT_CH, OUT_VALID);
    end
    $display("midrst during reset out=%0d ch=%0d v=%0b", OUT, OUT_CH, OUT_VALID);
    RST_N = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (OUT_CH !== SW'(c) || OUT_VALID !== 1'b1) begin
        n_fail++;
        $display("FAIL midrst_resume cyc=%0d got ch=%0d v=%0b exp ch=%0d v=1", c, OUT_CH, OUT_VALID, c);
      end
      $display("midrst resume cyc=%0d ch=%0d v=%0b", c, OUT_CH, OUT_VALID);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    RST_N     = 1'b0;
    MODE      = 1'b0;
    SEL_IN    = '0;
    IN_DATA   = '0;
    IN_VALID  = '0;
    OUT_READY = 1'b0;
    test_reset();
    test_manual();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
